// File: rtl/ysyx_220053_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_220053_pkg
// Shared definitions for the instruction fetch unit: reset PC default, the
// ebreak encoding, RISC-V opcode/func3 field positions and the IFU state type.
// ---------------------------------------------------------------------------
package ysyx_220053_pkg;

    localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;
    localparam logic [31:0] EBREAK_INSN  = 32'h0010_0073;

    localparam int OP_LSB    = 0;
    localparam int OP_MSB    = 6;
    localparam int FUNC3_LSB = 12;
    localparam int FUNC3_MSB = 14;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/ysyx_220053_ifu_if.sv
// ---------------------------------------------------------------------------
// ysyx_220053_ifu_if
// Bundles every bus the fetch unit talks on:
//   imem_req_*  : fetch request channel (valid/ready, word address)
//   imem_rsp_*  : in-order instruction return, no backpressure
//   redirect_*  : PC redirect from the branch/jump path
//   out_*       : instruction handed to decode (valid/ready)
// Modport master = fetch unit side, slave = memory/decode/redirect side.
// ---------------------------------------------------------------------------
interface ysyx_220053_ifu_if #(
    parameter int XLEN = 64
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [6:0]      out_op;
    logic [2:0]      out_func3;
    logic [XLEN-1:0] out_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output out_valid, out_instr, out_op, out_func3, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  out_valid, out_instr, out_op, out_func3, out_pc,
        output out_ready
    );
endinterface

// File: rtl/ysyx_220053_sync_fifo.sv
// ---------------------------------------------------------------------------
// ysyx_220053_sync_fifo
// Small synchronous FIFO with registered storage.
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   i_push     : write i_data (ignored when full unless popping too)
//   i_pop      : remove the head (ignored when empty)
//   i_flush    : drop all entries; wins over push/pop
//   o_count    : current occupancy
//   o_head     : oldest entry (undefined content when empty)
// Push and pop together are accepted at any occupancy, including full.
// ---------------------------------------------------------------------------
module ysyx_220053_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [CW-1:0]    o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    // When full, a simultaneous pop frees the slot under r_wr (== r_rd).
    assign w_push  = i_push && (!w_full || i_pop);
    assign w_pop   = i_pop && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= ptr_inc(r_wr);
            if (w_pop)  r_rd <= ptr_inc(r_rd);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wr] <= i_data;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/ysyx_220053_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_220053_ifu
// Instruction fetch unit: owns the PC, issues word fetches, buffers returned
// instructions and hands them to decode. A redirect flushes the buffer and
// discards every response still in flight for the old path.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ysyx_220053_ifu_if.master (imem req/rsp, redirect, out_*)
// Optional feature: define IFU_HALT_ON_EBREAK_EN to stop fetching once an
// ebreak word is accepted into the buffer (left via redirect or reset).
// ---------------------------------------------------------------------------
module ysyx_220053_ifu
    import ysyx_220053_pkg::*;
#(
    parameter int              XLEN            = 64,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEF),
    parameter int              FIFO_DEPTH      = 2,
    parameter int              MAX_OUTSTANDING = 2
) (
    input logic               clk,
    input logic               rst_n,
    ysyx_220053_ifu_if.master bus
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = ((OW > FW) ? OW : FW) + 1;
    localparam int IW = XLEN + 32;

    ifu_state_t      r_state;
    ifu_state_t      w_state_nxt;
    logic [XLEN-1:0] r_fetch_pc;
    logic [OW-1:0]   r_drop_cnt;
    logic [OW-1:0]   w_drop_nxt;
    logic [OW-1:0]   w_outstanding;
    logic [OW-1:0]   w_out_after_rsp;
    logic [FW-1:0]   w_ibuf_count;
    logic [XLEN-1:0] w_pcq_head;
    logic [XLEN-1:0] w_redirect_pc;
    logic [IW-1:0]   w_ibuf_head;
    logic [31:0]     w_instr;
    logic            w_redirect;
    logic            w_rsp_any;
    logic            w_rsp_keep;
    logic            w_credit;
    logic            w_fetch_en;
    logic            w_req_valid;
    logic            w_issue;
    logic            w_out_valid;
    logic            w_pop;

    assign w_redirect    = bus.redirect_valid;
    assign w_redirect_pc = bus.redirect_pc & ~XLEN'(3);

    // A response with nothing outstanding (e.g. one issued before a reset)
    // matches no request and is ignored.
    assign w_rsp_any       = bus.imem_rsp_valid && (w_outstanding != '0);
    assign w_rsp_keep      = w_rsp_any && (r_drop_cnt == '0) && !w_redirect;
    assign w_out_after_rsp = w_outstanding - OW'(w_rsp_any);
    assign w_drop_nxt      = (w_rsp_any && (r_drop_cnt != '0)) ? r_drop_cnt - OW'(1)
                                                               : r_drop_cnt;

    // Every issued request reserves a buffer slot, so the buffer cannot overflow.
    assign w_credit = ((SW'(w_outstanding) + SW'(w_ibuf_count)) < SW'(FIFO_DEPTH))
                   && (w_outstanding < OW'(MAX_OUTSTANDING));

`ifdef IFU_HALT_ON_EBREAK_EN
    assign w_fetch_en = (r_state != HALT);
`else
    assign w_fetch_en = 1'b1;
`endif

    assign w_req_valid = rst_n && w_fetch_en && (r_drop_cnt == '0) && w_credit && !w_redirect;
    assign w_issue     = w_req_valid && bus.imem_req_ready;

    // Pending-PC queue: one entry per issued request, popped by every
    // response (kept or dropped), so its occupancy is the outstanding count.
    ysyx_220053_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUTSTANDING)
    ) u_pcq (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_issue),
        .i_pop   (w_rsp_any),
        .i_flush (1'b0),
        .i_data  (r_fetch_pc),
        .o_count (w_outstanding),
        .o_head  (w_pcq_head)
    );

    ysyx_220053_sync_fifo #(
        .WIDTH (IW),
        .DEPTH (FIFO_DEPTH)
    ) u_ibuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_rsp_keep),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_data  ({w_pcq_head, bus.imem_rsp_data}),
        .o_count (w_ibuf_count),
        .o_head  (w_ibuf_head)
    );

    assign w_out_valid = (w_ibuf_count != '0);
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_instr     = w_out_valid ? w_ibuf_head[31:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_redirect) begin
                r_fetch_pc <= w_redirect_pc;
                // Everything still in flight belongs to the old path.
                r_drop_cnt <= w_out_after_rsp;
            end else begin
                if (w_issue) r_fetch_pc <= r_fetch_pc + XLEN'(4);
                r_drop_cnt <= w_drop_nxt;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
`ifdef IFU_HALT_ON_EBREAK_EN
                if (w_rsp_keep && (bus.imem_rsp_data == EBREAK_INSN)) w_state_nxt = HALT;
`endif
            end
            DRAIN: begin
                if (w_drop_nxt == '0) w_state_nxt = RUN;
            end
            default: w_state_nxt = r_state;
        endcase
        if (w_redirect) w_state_nxt = (w_out_after_rsp != '0) ? DRAIN : RUN;
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.out_valid      = w_out_valid;
    assign bus.out_instr      = w_instr;
    assign bus.out_op         = w_instr[OP_MSB:OP_LSB];
    assign bus.out_func3      = w_instr[FUNC3_MSB:FUNC3_LSB];
    assign bus.out_pc         = w_out_valid ? w_ibuf_head[IW-1:32] : '0;

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_220053_ifu
// Bench for the fetch unit: a 1-cycle-latency instruction memory model,
// a per-cycle vector table for start-up and backpressure, and directed
// sequences for redirects, handshake stalls, reset and ebreak handling.
// ---------------------------------------------------------------------------
module tb_ysyx_220053_ifu;
    import ysyx_220053_pkg::*;

    localparam int XLEN = 64;
    localparam logic [63:0] RPC = 64'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_220053_ifu_if #(.XLEN(XLEN)) bus();

    ysyx_220053_ifu #(
        .XLEN            (XLEN),
        .RESET_PC        (RPC),
        .FIFO_DEPTH      (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        rdy;
        logic        ordy;
        logic        exp_rv;
        logic [63:0] exp_addr;
        logic        exp_ov;
        logic [63:0] exp_pc;
    } vec_t;

    int          nchk = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          last_req_cyc = 0;
    int          n_deliv = 0;
    logic [63:0] exp_pc;
    logic [63:0] ebreak_addr;
    logic        mem_stall;
    logic        prev_stall;
    logic [63:0] prev_addr;
    logic [63:0] mq [$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == ebreak_addr) return EBREAK_INSN;
        return {a[23:0], a[9:2]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_mem();
        bus.imem_rsp_valid = !mem_stall && (mq.size() > 0);
        bus.imem_rsp_data  = (mq.size() > 0) ? mem_word(mq[0]) : 32'h0;
    endtask

    // Sample just before the edge, then advance to the next falling edge and
    // update the memory model with what happened at the rising edge.
    task automatic tick();
        logic        hs;
        logic        rf;
        logic [63:0] ha;
        logic [31:0] w;
        #1;
        hs = bus.imem_req_valid && bus.imem_req_ready;
        ha = bus.imem_req_addr;
        rf = bus.imem_rsp_valid;
        if (bus.imem_req_valid) last_req_cyc = cyc;
        prev_stall = bus.imem_req_valid && !bus.imem_req_ready;
        prev_addr  = ha;
        if (bus.out_valid && bus.out_ready) begin
            w = mem_word(exp_pc);
            check("deliver", {bus.out_pc, bus.out_instr, bus.out_op, bus.out_func3},
                  {exp_pc, w, w[6:0], w[14:12]});
            exp_pc = exp_pc + 64'd4;
            n_deliv++;
        end
        if (bus.redirect_valid) exp_pc = {bus.redirect_pc[63:2], 2'b00};
        @(negedge clk);
        cyc++;
        if (rf && mq.size() > 0) void'(mq.pop_front());
        if (hs) mq.push_back(ha);
        drive_mem();
    endtask

    task automatic do_reset(input logic [63:0] ebk);
        rst_n = 1'b0;
        ebreak_addr = ebk;
        mq.delete();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        drive_mem();
        #1;
        check("reset_state", {bus.imem_req_valid, bus.out_valid, bus.out_instr, bus.out_pc}, '0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = RPC;
        drive_mem();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [14];
        int   n;
        int   base;
        int   lat;

        tbl[0]  = '{1'b1, 1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 64'h8000_0004, 1'b0, 64'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 64'h0,         1'b1, 64'h8000_0000};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 64'h8000_000C, 1'b0, 64'h0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 64'h0,         1'b1, 64'h8000_0008};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_000C};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 64'h8000_0014, 1'b0, 64'h0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_0010};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_0010};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 64'h0,         1'b1, 64'h8000_0010};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 64'h0,         1'b1, 64'h8000_0010};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 64'h8000_0018, 1'b1, 64'h8000_0014};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 64'h8000_001C, 1'b0, 64'h0};

        mem_stall          = 1'b0;
        prev_stall         = 1'b0;
        prev_addr          = '0;
        exp_pc             = RPC;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        do_reset(64'hFFFF_FFFF_FFFF_FFFF);

        // Start-up stream and backpressure, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            bus.imem_req_ready = tbl[i].rdy;
            bus.out_ready      = tbl[i].ordy;
            #1;
            check("tbl_req", {bus.imem_req_valid, tbl[i].exp_rv ? bus.imem_req_addr : 64'h0},
                  {tbl[i].exp_rv, tbl[i].exp_addr});
            check("tbl_out", {bus.out_valid, tbl[i].exp_ov ? bus.out_pc : 64'h0},
                  {tbl[i].exp_ov, tbl[i].exp_pc});
            tick();
        end

        // Redirect with two requests in flight: both responses must vanish.
        mem_stall = 1'b1;
        drive_mem();
        n = 0;
        while (mq.size() < 2 && n < 10) begin
            tick();
            n++;
        end
        check("two_outstanding", mq.size(), 2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0100;
        #1;
        check("redir_noreq", bus.imem_req_valid, 1'b0);
        tick();
        bus.redirect_valid = 1'b0;
        mem_stall = 1'b0;
        drive_mem();
        #1;
        check("drain_noreq", {bus.imem_req_valid, bus.out_valid}, 2'b00);
        base = n_deliv;
        n = 0;
        while (n_deliv - base < 3 && n < 40) begin
            tick();
            n++;
        end
        check("redir_resume", n_deliv - base >= 3, 1'b1);

        // Misaligned target, redirect in the same cycle as a response.
        n = 0;
        while (!(bus.imem_rsp_valid && mq.size() == 1) && n < 20) begin
            tick();
            n++;
        end
        check("rsp_wait", n < 20, 1'b1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0102;
        #1;
        check("redir2_noreq", bus.imem_req_valid, 1'b0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        check("aligned_addr", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, 64'h8000_0100});
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("redir_latency", lat, 3);
        check("redir_first_pc", bus.out_pc, 64'h8000_0100);

        // Random request/decode backpressure: address must hold while stalled.
        for (int i = 0; i < 60; i++) begin
            bus.imem_req_ready = 1'($urandom_range(0, 1));
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall)
                check("addr_hold", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, prev_addr});
            tick();
        end
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        repeat (8) tick();

        // Asynchronous reset in the middle of traffic.
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst", {bus.imem_req_valid, bus.out_valid, bus.out_instr, bus.out_pc}, '0);
        @(negedge clk);
        do_reset(64'h8000_0010);
        #1;
        check("post_rst_addr", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, RPC});

        // ebreak fetched at 0x80000010.
        repeat (30) tick();
`ifdef IFU_HALT_ON_EBREAK_EN
        check("halt_noreq", (cyc - last_req_cyc) >= 10, 1'b1);
        check("halt_drained", {bus.out_valid, exp_pc}, {1'b0, 64'h8000_0018});
`else
        check("no_halt", exp_pc > 64'h8000_0030, 1'b1);
`endif
        ebreak_addr = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = RPC;
        tick();
        bus.redirect_valid = 1'b0;
        n = 0;
        #1;
        while (!bus.imem_req_valid && n < 10) begin
            tick();
            n++;
        end
        check("resume_addr", {bus.imem_req_valid, bus.imem_req_addr}, {1'b1, RPC});
        base = n_deliv;
        repeat (10) tick();
        check("resume_deliver", n_deliv - base >= 2, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
